sobel_edge_detector: RTL and testbench

Consumes the grayscale 3x3 pixel matrix stream from `buffered_matrix_colorspace_converter` and computes the Sobel gradient magnitude for the matrix centre pixel. It produces a saturated magnitude, a thresholded edge bit and the centre coordinates. It also keeps a per-frame edge-pixel count for the downstream frame writer and status logic. The block is a 3-stage pipeline in the `I_CLK` domain.

---
 rtl/sobel_edge_detector.sv | 162 ++++++++++++++++
 tb/tb_sobel_edge_detector.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_edge_detector.sv
// sobel_edge_detector
// Three-stage Sobel gradient pipeline over a streamed 3x3 grayscale matrix.
// Stage 1 registers the matrix and the centre coordinates. Stage 2 registers
// the signed Gx/Gy gradients. Stage 3 registers the saturated magnitude, the
// thresholded edge bit and the per-frame edge count.
module sobel_edge_detector #(
    parameter int P_FRAME_COLUMNS  = 640,
    parameter int P_FRAME_ROWS     = 480,
    parameter int P_SUBPIXEL_DEPTH = 8,
    parameter int P_THRESHOLD      = 128,
    localparam int LP_COL_W = $clog2(P_FRAME_COLUMNS),
    localparam int LP_ROW_W = $clog2(P_FRAME_ROWS),
    localparam int LP_CNT_W = $clog2(P_FRAME_COLUMNS * P_FRAME_ROWS + 1)
) (
    input  logic                          I_CLK,
    input  logic                          I_RESET,
    input  logic                          I_ENABLE,
    input  logic [LP_COL_W-1:0]           I_PIXEL_COLUMN,
    input  logic [LP_ROW_W-1:0]           I_PIXEL_ROW,
    input  logic [9*P_SUBPIXEL_DEPTH-1:0] I_PIXEL_MATRIX,
    input  logic                          I_PIXEL_MATRIX_READY,
    output logic [LP_COL_W-1:0]           O_PIXEL_COLUMN,
    output logic [LP_ROW_W-1:0]           O_PIXEL_ROW,
    output logic [P_SUBPIXEL_DEPTH-1:0]   O_MAGNITUDE,
    output logic                          O_EDGE,
    output logic                          O_PIXEL_READY,
    output logic [LP_CNT_W-1:0]           O_EDGE_COUNT,
    output logic                          O_FRAME_DONE
);

    localparam int LP_D  = P_SUBPIXEL_DEPTH;
    localparam int LP_GW = P_SUBPIXEL_DEPTH + 3;

    localparam logic [LP_GW-1:0]    LP_THRESH   = LP_GW'(P_THRESHOLD);
    localparam logic [LP_GW-1:0]    LP_PIX_MAX  = LP_GW'((1 << P_SUBPIXEL_DEPTH) - 1);
    localparam logic [LP_COL_W-1:0] LP_LAST_COL = LP_COL_W'(P_FRAME_COLUMNS - 2);
    localparam logic [LP_ROW_W-1:0] LP_LAST_ROW = LP_ROW_W'(P_FRAME_ROWS - 2);

    // Stage 1 registers
    logic                  r_s1Valid;
    logic [9*LP_D-1:0]     r_s1Matrix;
    logic [LP_COL_W-1:0]   r_s1Column;
    logic [LP_ROW_W-1:0]   r_s1Row;

    // Stage 2 registers (gradients are two's complement, LP_GW bits)
    logic                  r_s2Valid;
    logic [LP_GW-1:0]      r_s2Gx;
    logic [LP_GW-1:0]      r_s2Gy;
    logic [LP_COL_W-1:0]   r_s2Column;
    logic [LP_ROW_W-1:0]   r_s2Row;

    // Running edge count of the frame in progress
    logic [LP_CNT_W-1:0]   r_edgeCount;

    // Combinational terms
    logic [LP_GW-1:0]      w_gxPos;
    logic [LP_GW-1:0]      w_gxNeg;
    logic [LP_GW-1:0]      w_gyPos;
    logic [LP_GW-1:0]      w_gyNeg;
    logic [LP_GW-1:0]      w_absGx;
    logic [LP_GW-1:0]      w_absGy;
    logic [LP_GW-1:0]      w_mag;
    logic                  w_edge;
    logic                  w_isLast;
    logic [LP_CNT_W-1:0]   w_edgeInc;
    logic                  w_unusedCentre;

    // Zero-extend one matrix element (index 3r+c) to gradient width
    function automatic logic [LP_GW-1:0] pix(input logic [9*LP_D-1:0] m, input int idx);
        return LP_GW'(m[idx*LP_D +: LP_D]);
    endfunction

    // The centre pixel has zero weight in both Sobel kernels
    assign w_unusedCentre = ^r_s1Matrix[4*LP_D +: LP_D];

    // Stage 1: capture an accepted matrix and pre-compute the centre coordinates
    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            r_s1Valid  <= 1'b0;
            r_s1Matrix <= '0;
            r_s1Column <= '0;
            r_s1Row    <= '0;
        end else if (I_ENABLE) begin
            r_s1Valid <= I_PIXEL_MATRIX_READY;
            if (I_PIXEL_MATRIX_READY) begin
                r_s1Matrix <= I_PIXEL_MATRIX;
                r_s1Column <= I_PIXEL_COLUMN + LP_COL_W'(1);
                r_s1Row    <= I_PIXEL_ROW + LP_ROW_W'(1);
            end
        end
    end

    // Weighted column/row sums; each side is non-negative and at most 4*(2^D-1)
    always_comb begin
        w_gxPos = pix(r_s1Matrix, 2) + (pix(r_s1Matrix, 5) << 1) + pix(r_s1Matrix, 8);
        w_gxNeg = pix(r_s1Matrix, 0) + (pix(r_s1Matrix, 3) << 1) + pix(r_s1Matrix, 6);
        w_gyPos = pix(r_s1Matrix, 6) + (pix(r_s1Matrix, 7) << 1) + pix(r_s1Matrix, 8);
        w_gyNeg = pix(r_s1Matrix, 0) + (pix(r_s1Matrix, 1) << 1) + pix(r_s1Matrix, 2);
    end

    // Stage 2: register signed gradients; the difference always fits in D+3 bits
    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            r_s2Valid  <= 1'b0;
            r_s2Gx     <= '0;
            r_s2Gy     <= '0;
            r_s2Column <= '0;
            r_s2Row    <= '0;
        end else if (I_ENABLE) begin
            r_s2Valid <= r_s1Valid;
            if (r_s1Valid) begin
                r_s2Gx     <= w_gxPos - w_gxNeg;
                r_s2Gy     <= w_gyPos - w_gyNeg;
                r_s2Column <= r_s1Column;
                r_s2Row    <= r_s1Row;
            end
        end
    end

    // Magnitude, threshold and last-centre detection for the stage-2 result
    always_comb begin
        w_absGx   = r_s2Gx[LP_GW-1] ? (~r_s2Gx + LP_GW'(1)) : r_s2Gx;
        w_absGy   = r_s2Gy[LP_GW-1] ? (~r_s2Gy + LP_GW'(1)) : r_s2Gy;
        w_mag     = w_absGx + w_absGy;
        w_edge    = (w_mag >= LP_THRESH);
        w_isLast  = (r_s2Column == LP_LAST_COL) && (r_s2Row == LP_LAST_ROW);
        w_edgeInc = LP_CNT_W'(w_edge);
    end

    // Stage 3: registered outputs and frame edge counter; strobes drop while disabled
    always_ff @(posedge I_CLK or posedge I_RESET) begin
        if (I_RESET) begin
            O_PIXEL_READY  <= 1'b0;
            O_FRAME_DONE   <= 1'b0;
            O_MAGNITUDE    <= '0;
            O_EDGE         <= 1'b0;
            O_PIXEL_COLUMN <= '0;
            O_PIXEL_ROW    <= '0;
            O_EDGE_COUNT   <= '0;
            r_edgeCount    <= '0;
        end else if (I_ENABLE) begin
            O_PIXEL_READY <= r_s2Valid;
            O_FRAME_DONE  <= r_s2Valid && w_isLast;
            if (r_s2Valid) begin
                O_MAGNITUDE    <= (w_mag > LP_PIX_MAX) ? '1 : w_mag[LP_D-1:0];
                O_EDGE         <= w_edge;
                O_PIXEL_COLUMN <= r_s2Column;
                O_PIXEL_ROW    <= r_s2Row;
                if (w_isLast) begin
                    O_EDGE_COUNT <= r_edgeCount + w_edgeInc;
                    r_edgeCount  <= '0;
                end else begin
                    r_edgeCount  <= r_edgeCount + w_edgeInc;
                end
            end
        end else begin
            O_PIXEL_READY <= 1'b0;
            O_FRAME_DONE  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sobel_edge_detector.sv
// tb_sobel_edge_detector
// Directed bench for sobel_edge_detector on a reduced 32x24 frame so that a
// complete frame (30x22 centres) fits in a short run.
module tb_sobel_edge_detector;

    localparam int COLS = 32;
    localparam int ROWS = 24;
    localparam int D    = 8;
    localparam int THR  = 128;
    localparam int CW   = $clog2(COLS);
    localparam int RW   = $clog2(ROWS);
    localparam int NW   = $clog2(COLS * ROWS + 1);

    logic            I_CLK = 1'b0;
    logic            I_RESET = 1'b1;
    logic            I_ENABLE = 1'b0;
    logic [CW-1:0]   I_PIXEL_COLUMN = '0;
    logic [RW-1:0]   I_PIXEL_ROW = '0;
    logic [9*D-1:0]  I_PIXEL_MATRIX = '0;
    logic            I_PIXEL_MATRIX_READY = 1'b0;
    logic [CW-1:0]   O_PIXEL_COLUMN;
    logic [RW-1:0]   O_PIXEL_ROW;
    logic [D-1:0]    O_MAGNITUDE;
    logic            O_EDGE;
    logic            O_PIXEL_READY;
    logic [NW-1:0]   O_EDGE_COUNT;
    logic            O_FRAME_DONE;

    int checks = 0;
    int failures = 0;

    sobel_edge_detector #(
        .P_FRAME_COLUMNS (COLS),
        .P_FRAME_ROWS    (ROWS),
        .P_SUBPIXEL_DEPTH(D),
        .P_THRESHOLD     (THR)
    ) dut (
        .I_CLK               (I_CLK),
        .I_RESET             (I_RESET),
        .I_ENABLE            (I_ENABLE),
        .I_PIXEL_COLUMN      (I_PIXEL_COLUMN),
        .I_PIXEL_ROW         (I_PIXEL_ROW),
        .I_PIXEL_MATRIX      (I_PIXEL_MATRIX),
        .I_PIXEL_MATRIX_READY(I_PIXEL_MATRIX_READY),
        .O_PIXEL_COLUMN      (O_PIXEL_COLUMN),
        .O_PIXEL_ROW         (O_PIXEL_ROW),
        .O_MAGNITUDE         (O_MAGNITUDE),
        .O_EDGE              (O_EDGE),
        .O_PIXEL_READY       (O_PIXEL_READY),
        .O_EDGE_COUNT        (O_EDGE_COUNT),
        .O_FRAME_DONE        (O_FRAME_DONE)
    );

    // 100 MHz clock
    always #5 I_CLK = ~I_CLK;

    // Build a flattened matrix; element [r][c] lands at bits (3r+c)*D
    function automatic logic [9*D-1:0] mk(input int p00, input int p01, input int p02,
                                          input int p10, input int p11, input int p12,
                                          input int p20, input int p21, input int p22);
        int v [9];
        logic [9*D-1:0] m;
        v = '{p00, p01, p02, p10, p11, p12, p20, p21, p22};
        m = '0;
        for (int i = 0; i < 9; i++) m[i*D +: D] = v[i][D-1:0];
        return m;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag, input int rdy, input int mag, input int edg,
                            input int col, input int row);
        checkOutput({tag, ".ready"}, 32'(O_PIXEL_READY), rdy);
        checkOutput({tag, ".mag"},   32'(O_MAGNITUDE),   mag);
        checkOutput({tag, ".edge"},  32'(O_EDGE),        edg);
        checkOutput({tag, ".col"},   32'(O_PIXEL_COLUMN), col);
        checkOutput({tag, ".row"},   32'(O_PIXEL_ROW),   row);
    endtask

    task automatic applyStimulus(input int col, input int row, input logic [9*D-1:0] m);
        I_PIXEL_COLUMN       = CW'(col);
        I_PIXEL_ROW          = RW'(row);
        I_PIXEL_MATRIX       = m;
        I_PIXEL_MATRIX_READY = 1'b1;
    endtask

    // One isolated matrix; result must be absent after two edges and present after three
    task automatic runSingle(input string tag, input int col, input int row,
                             input logic [9*D-1:0] m, input int mag, input int edg);
        @(negedge I_CLK);
        applyStimulus(col, row, m);
        @(negedge I_CLK);
        I_PIXEL_MATRIX_READY = 1'b0;
        @(negedge I_CLK);
        checkOutput({tag, ".early"}, 32'(O_PIXEL_READY), 0);
        @(negedge I_CLK);
        checkAll(tag, 1, mag, edg, col + 1, row + 1);
    endtask

    logic [9*D-1:0] vert;
    logic [9*D-1:0] flat;
    int streamMag [8] = '{40, 80, 120, 160, 200, 240, 255, 255};
    int streamEdge[8] = '{0, 0, 0, 1, 1, 1, 1, 1};

    initial begin
        int sent;
        int outIdx;
        int readyCnt;
        int doneCnt;
        int doneCol;
        int doneRow;
        int doneCount;
        int v;

        vert = mk(0, 0, 255, 0, 0, 255, 0, 0, 255);
        flat = mk(100, 100, 100, 100, 100, 100, 100, 100, 100);

        // Reset state
        #12;
        checkAll("reset", 0, 0, 0, 0, 0);
        checkOutput("reset.count", 32'(O_EDGE_COUNT), 0);
        checkOutput("reset.done",  32'(O_FRAME_DONE), 0);
        @(negedge I_CLK);
        I_RESET  = 1'b0;
        I_ENABLE = 1'b1;

        // Single-matrix gradient cases
        runSingle("flat",    10, 20, flat, 0, 0);
        runSingle("vert",     3,  4, vert, 255, 1);
        runSingle("thr128",   5,  6, mk(0, 0, 32, 0, 0, 32, 0, 0, 32), 128, 1);
        runSingle("thr124",   5,  7, mk(0, 0, 31, 0, 0, 31, 0, 0, 31), 124, 0);
        runSingle("topRow",   8,  9, mk(10, 10, 10, 0, 0, 0, 0, 0, 0), 40, 0);
        runSingle("corner",   1,  1, mk(50, 0, 0, 0, 0, 0, 0, 0, 0), 100, 0);
        runSingle("bottom",   0,  0, mk(0, 0, 0, 0, 0, 0, 200, 200, 200), 255, 1);
        runSingle("diag",     2, 12, mk(0, 0, 0, 0, 0, 0, 0, 0, 40), 80, 0);

        // Back-to-back stream of 8 with enable low for two cycles mid-stream
        sent   = 0;
        outIdx = 0;
        for (int cyc = 0; cyc < 25; cyc++) begin
            @(negedge I_CLK);
            if (O_PIXEL_READY) begin
                if (outIdx < 8) begin
                    checkOutput($sformatf("stream%0d.col", outIdx), 32'(O_PIXEL_COLUMN), outIdx + 2);
                    checkOutput($sformatf("stream%0d.row", outIdx), 32'(O_PIXEL_ROW), 3);
                    checkOutput($sformatf("stream%0d.mag", outIdx), 32'(O_MAGNITUDE), streamMag[outIdx]);
                    checkOutput($sformatf("stream%0d.edge", outIdx), 32'(O_EDGE), streamEdge[outIdx]);
                end
                outIdx++;
            end
            I_ENABLE = !(cyc == 4 || cyc == 5);
            if (sent < 8) begin
                v = 10 * (sent + 1);
                applyStimulus(sent + 1, 2, mk(0, 0, v, 0, 0, v, 0, 0, v));
                if (I_ENABLE) sent++;
            end else begin
                I_PIXEL_MATRIX_READY = 1'b0;
            end
        end
        I_ENABLE = 1'b1;
        checkOutput("stream.pulses", outIdx, 8);

        // Asynchronous reset with results in flight
        @(negedge I_CLK); applyStimulus(5, 5, vert);
        @(negedge I_CLK); applyStimulus(6, 5, vert);
        @(negedge I_CLK); applyStimulus(7, 5, vert);
        @(negedge I_CLK); I_PIXEL_MATRIX_READY = 1'b0;
        checkAll("preRst", 1, 255, 1, 6, 6);
        #2 I_RESET = 1'b1;
        #1;
        checkAll("asyncRst", 0, 0, 0, 0, 0);
        checkOutput("asyncRst.count", 32'(O_EDGE_COUNT), 0);
        @(negedge I_CLK);
        I_RESET = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge I_CLK);
            checkOutput($sformatf("postRst%0d.ready", cyc), 32'(O_PIXEL_READY), 0);
        end

        // Full frame, every matrix a vertical edge
        readyCnt  = 0;
        doneCnt   = 0;
        doneCol   = -1;
        doneRow   = -1;
        doneCount = -1;
        for (int idx = 0; idx < 665; idx++) begin
            @(negedge I_CLK);
            if (O_PIXEL_READY) readyCnt++;
            if (O_FRAME_DONE) begin
                doneCnt++;
                doneCol   = int'(O_PIXEL_COLUMN);
                doneRow   = int'(O_PIXEL_ROW);
                doneCount = int'(O_EDGE_COUNT);
            end
            if (idx < 660) applyStimulus(idx % 30, idx / 30, vert);
            else I_PIXEL_MATRIX_READY = 1'b0;
        end
        checkOutput("frame.readyCnt", readyCnt, 660);
        checkOutput("frame.doneCnt", doneCnt, 1);
        checkOutput("frame.doneCol", doneCol, 30);
        checkOutput("frame.doneRow", doneRow, 22);
        checkOutput("frame.doneCount", doneCount, 660);
        checkOutput("frame.countHeld", 32'(O_EDGE_COUNT), 660);

        // Second frame: counter restarts; done pulse survives enable falling
        @(negedge I_CLK); applyStimulus(0, 0, vert);
        @(negedge I_CLK); applyStimulus(1, 0, flat);
        @(negedge I_CLK); applyStimulus(2, 0, vert);
        @(negedge I_CLK); applyStimulus(29, 21, vert);
        @(negedge I_CLK); I_PIXEL_MATRIX_READY = 1'b0;
        @(negedge I_CLK);
        checkOutput("frame2.preDone", 32'(O_FRAME_DONE), 0);
        checkOutput("frame2.preCount", 32'(O_EDGE_COUNT), 660);
        @(negedge I_CLK);
        checkOutput("frame2.done", 32'(O_FRAME_DONE), 1);
        checkOutput("frame2.count", 32'(O_EDGE_COUNT), 3);
        checkAll("frame2.last", 1, 255, 1, 30, 22);
        I_ENABLE = 1'b0;
        @(negedge I_CLK);
        checkOutput("disabled.done", 32'(O_FRAME_DONE), 0);
        checkOutput("disabled.ready", 32'(O_PIXEL_READY), 0);
        checkOutput("disabled.count", 32'(O_EDGE_COUNT), 3);
        checkOutput("disabled.magHeld", 32'(O_MAGNITUDE), 255);
        checkOutput("disabled.colHeld", 32'(O_PIXEL_COLUMN), 30);
        I_ENABLE = 1'b1;
        @(negedge I_CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
